// File: rtl/fft_pkg.sv
// Shared definitions for the 256-point FFT output reorder path.
//   FFT_N / FFT_LOG2N / FFT_W : frame length, index width, component width
//   cplx_t                    : packed complex sample {r, i}
//   wr_state_t                : write-side FSM encoding
//   bitrev()                  : bit reversal of a FFT_LOG2N-bit index
package fft_pkg;

  localparam int FFT_N     = 256;
  localparam int FFT_LOG2N = 8;
  localparam int FFT_W     = 16;

  typedef struct packed {
    logic signed [FFT_W-1:0] r;
    logic signed [FFT_W-1:0] i;
  } cplx_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_FILL,
    WR_DROP
  } wr_state_t;

  function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] x);
    logic [FFT_LOG2N-1:0] y;
    y = '0;
    for (int b = 0; b < FFT_LOG2N; b++) begin
      y[b] = x[FFT_LOG2N-1-b];
    end
    return y;
  endfunction

endpackage

// File: rtl/fft_256_reorder_if.sv
// Stream bundle around the reorder buffer.
//   Input side : data_in_r/i, in_valid, in_sof (no backpressure)
//   Output side: data_out_r/i, out_valid, out_ready, out_sof, out_last
//   master: the environment (FFT datapath + downstream consumer)
//   slave : the reorder buffer itself
interface fft_256_reorder_if
  import fft_pkg::*;
#(
  parameter int W = FFT_W
);

  logic signed [W-1:0] data_in_r;
  logic signed [W-1:0] data_in_i;
  logic                in_valid;
  logic                in_sof;
  logic signed [W-1:0] data_out_r;
  logic signed [W-1:0] data_out_i;
  logic                out_valid;
  logic                out_ready;
  logic                out_sof;
  logic                out_last;

  modport master (
    output data_in_r, data_in_i, in_valid, in_sof, out_ready,
    input  data_out_r, data_out_i, out_valid, out_sof, out_last
  );

  modport slave (
    input  data_in_r, data_in_i, in_valid, in_sof, out_ready,
    output data_out_r, data_out_i, out_valid, out_sof, out_last
  );

endinterface

// File: rtl/fft_reorder_bank.sv
// One reorder bank: simple dual-port RAM, one write and one read port,
// synchronous read with read enable so rdata holds while the consumer stalls.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, rdata valid the cycle after re
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int DEPTH = FFT_N,
  parameter int AW    = FFT_LOG2N,
  parameter int DW    = 2 * FFT_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_256_reorder.sv
// Ping-pong reorder buffer: collects bit-reversed FFT frames into one of two
// banks and replays each complete bank in natural order over valid/ready.
//   CLK, RST  : clock, asynchronous active-low reset
//   bus       : input stream (bit-reversed) and output stream (natural order)
//   clr_err   : synchronous clear of the sticky flags (a same-cycle set wins)
//   overflow  : sticky, a frame was dropped because no bank was free
//   misalign  : sticky, in_sof arrived in the middle of a frame
module fft_256_reorder
  import fft_pkg::*;
#(
  parameter int N     = FFT_N,
  parameter int LOG2N = FFT_LOG2N,
  parameter int W     = FFT_W
) (
  input  logic             CLK,
  input  logic             RST,
  fft_256_reorder_if.slave bus,
  input  logic             clr_err,
  output logic             overflow,
  output logic             misalign
);

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  wr_state_t        wr_state, wr_state_nxt;
  logic [LOG2N-1:0] wr_cnt, wr_cnt_nxt;
  logic             wr_bank, wr_bank_nxt;
  logic             sof_hit;
  logic             wr_en, set_full, ovf_set, mis_set;
  logic [LOG2N-1:0] wr_addr;
  logic [2*W-1:0]   wr_data;

  logic [1:0]       full, full_nxt;
  logic             rd_bank, rd_issue, rd_done;
  logic [LOG2N-1:0] rd_cnt;
  logic [2*W-1:0]   rd_q [2];

  logic             out_valid_q, out_sof_q, out_last_q, out_bank;
  cplx_t            out_q;

  assign sof_hit = bus.in_valid && bus.in_sof;
  assign wr_data = {bus.data_in_r, bus.data_in_i};

  // Write FSM: state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_state <= WR_IDLE;
      wr_cnt   <= '0;
      wr_bank  <= 1'b0;
    end else begin
      wr_state <= wr_state_nxt;
      wr_cnt   <= wr_cnt_nxt;
      wr_bank  <= wr_bank_nxt;
    end
  end

  // Write FSM: next state
  always_comb begin
    wr_state_nxt = wr_state;
    wr_cnt_nxt   = wr_cnt;
    wr_bank_nxt  = wr_bank;
    case (wr_state)
      WR_IDLE, WR_DROP: begin
        if (sof_hit) begin
          if (full[wr_bank]) begin
            wr_state_nxt = WR_DROP;
          end else begin
            wr_state_nxt = WR_FILL;
            wr_cnt_nxt   = LOG2N'(1);
          end
        end
      end
      WR_FILL: begin
        if (bus.in_valid) begin
          if (bus.in_sof) begin
            // Restart the frame in place; the partial data is overwritten.
            wr_cnt_nxt = LOG2N'(1);
          end else if (wr_cnt == LAST_IDX) begin
            wr_state_nxt = WR_IDLE;
            wr_cnt_nxt   = '0;
            wr_bank_nxt  = ~wr_bank;
          end else begin
            wr_cnt_nxt = wr_cnt + LOG2N'(1);
          end
        end
      end
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  // Write FSM: outputs
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = bitrev(wr_cnt);
    set_full = 1'b0;
    ovf_set  = 1'b0;
    mis_set  = 1'b0;
    case (wr_state)
      WR_IDLE, WR_DROP: begin
        if (sof_hit) begin
          if (full[wr_bank]) ovf_set = 1'b1;
          else begin
            wr_en   = 1'b1;
            wr_addr = '0;
          end
        end
      end
      WR_FILL: begin
        if (bus.in_valid) begin
          wr_en = 1'b1;
          if (bus.in_sof) begin
            mis_set = 1'b1;
            wr_addr = '0;
          end else if (wr_cnt == LAST_IDX) begin
            set_full = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Read side: issue whenever the output slot is empty or being drained.
  assign rd_issue = full[rd_bank] && (!out_valid_q || bus.out_ready);
  assign rd_done  = rd_issue && (rd_cnt == LAST_IDX);

  // Write-complete and read-complete always target different banks, so both
  // updates can land in the same cycle.
  always_comb begin
    full_nxt = full;
    if (set_full) full_nxt[wr_bank] = 1'b1;
    if (rd_done)  full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      full        <= '0;
      rd_bank     <= 1'b0;
      rd_cnt      <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_bank    <= 1'b0;
      overflow    <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      full     <= full_nxt;
      overflow <= ovf_set | (overflow & ~clr_err);
      misalign <= mis_set | (misalign & ~clr_err);
      if (rd_issue) begin
        rd_cnt      <= rd_done ? '0 : rd_cnt + LOG2N'(1);
        if (rd_done) rd_bank <= ~rd_bank;
        out_valid_q <= 1'b1;
        out_sof_q   <= (rd_cnt == '0);
        out_last_q  <= (rd_cnt == LAST_IDX);
        out_bank    <= rd_bank;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Banks: the RAM read register doubles as the output data register.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank #(
      .DEPTH(N),
      .AW   (LOG2N),
      .DW   (2 * W)
    ) u_bank (
      .clk  (CLK),
      .we   (wr_en && (wr_bank == 1'(b))),
      .waddr(wr_addr),
      .wdata(wr_data),
      .re   (rd_issue && (rd_bank == 1'(b))),
      .raddr(rd_cnt),
      .rdata(rd_q[b])
    );
  end

  // Data is forced to zero while no sample is held, giving clean reset values.
  assign out_q          = cplx_t'(rd_q[out_bank]);
  assign bus.data_out_r = out_valid_q ? out_q.r : '0;
  assign bus.data_out_i = out_valid_q ? out_q.i : '0;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sof    = out_valid_q & out_sof_q;
  assign bus.out_last   = out_valid_q & out_last_q;

endmodule

// File: tb/tb_fft_256_reorder.sv
module tb_fft_256_reorder;

  logic clk = 1'b0;
  logic rst_n;
  logic clr_err;
  logic overflow, misalign;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  typedef struct {
    logic [15:0] r;
    logic [15:0] i;
    logic        sof;
    logic        last;
    int          cyc;
  } smp_t;

  smp_t q[$];

  fft_256_reorder_if bus ();

  fft_256_reorder dut (
    .CLK     (clk),
    .RST     (rst_n),
    .bus     (bus),
    .clr_err (clr_err),
    .overflow(overflow),
    .misalign(misalign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted output sample (handshake completes at next posedge).
  always @(negedge clk) begin
    smp_t s;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      s.r    = bus.data_out_r;
      s.i    = bus.data_out_i;
      s.sof  = bus.out_sof;
      s.last = bus.out_last;
      s.cyc  = cyc;
      q.push_back(s);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int tb_bitrev(input int k);
    int r = 0;
    for (int b = 0; b < 8; b++) if (k & (1 << b)) r |= 1 << (7 - b);
    return r;
  endfunction

  function automatic logic [15:0] exp_r(input int f, input int n);
    return 16'(n + 256 * f);
  endfunction

  function automatic logic [15:0] exp_i(input int f, input int n);
    return 16'(20000 - 3 * n - 7 * f);
  endfunction

  // Drive nsamp samples of frame f in bit-reversed order, one per cycle.
  task automatic drive_frame(input int f, input int nsamp, input bit clr_on_sof);
    for (int k = 0; k < nsamp; k++) begin
      bus.data_in_r = exp_r(f, tb_bitrev(k));
      bus.data_in_i = exp_i(f, tb_bitrev(k));
      bus.in_valid  = 1'b1;
      bus.in_sof    = (k == 0);
      clr_err       = clr_on_sof && (k == 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    clr_err      = 1'b0;
  endtask

  task automatic wait_outputs(input int n, input int bound);
    for (int c = 0; c < bound && q.size() < n; c++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clr_err = 1'b0;
    bus.data_in_r = '0; bus.data_in_i = '0;
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.data_out_r !== 16'sd0 || bus.data_out_i !== 16'sd0) begin errors++; $display("FAIL reset_data got %0d/%0d want 0/0", bus.data_out_r, bus.data_out_i); end
    checks++; if (bus.out_sof !== 1'b0 || bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_sof_last got %b%b want 00", bus.out_sof, bus.out_last); end
    checks++; if (overflow !== 1'b0 || misalign !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", overflow, misalign); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_single_frame;
    q.delete();
    bus.out_ready = 1'b1;
    drive_frame(1, 256, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL latency_early got valid=%b want 0", bus.out_valid); end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sof !== 1'b1 || bus.data_out_r !== 16'sd256) begin
      errors++; $display("FAIL latency_first got v=%b sof=%b r=%0d want v=1 sof=1 r=256", bus.out_valid, bus.out_sof, bus.data_out_r);
    end
    wait_outputs(256, 600);
    repeat (20) @(posedge clk); #1;
    checks++; if (q.size() != 256) begin errors++; $display("FAIL single_count got %0d want 256", q.size()); end
    for (int j = 0; j < q.size() && j < 256; j++) begin
      checks++;
      if (q[j].r !== exp_r(1, j) || q[j].i !== exp_i(1, j) || q[j].sof !== (j == 0) || q[j].last !== (j == 255)) begin
        errors++;
        $display("FAIL single_sample %0d got r=%0d i=%0d sof=%b last=%b want r=%0d i=%0d sof=%b last=%b",
                 j, q[j].r, q[j].i, q[j].sof, q[j].last, exp_r(1, j), exp_i(1, j), j == 0, j == 255);
      end
    end
  endtask

  task automatic test_back_to_back;
    q.delete();
    bus.out_ready = 1'b1;
    drive_frame(2, 256, 1'b0);
    drive_frame(3, 256, 1'b0);
    drive_frame(4, 256, 1'b0);
    wait_outputs(768, 1200);
    repeat (20) @(posedge clk); #1;
    checks++; if (q.size() != 768) begin errors++; $display("FAIL b2b_count got %0d want 768", q.size()); end
    for (int j = 0; j < q.size() && j < 768; j++) begin
      checks++;
      if (q[j].r !== exp_r(2 + j / 256, j % 256) || q[j].i !== exp_i(2 + j / 256, j % 256) ||
          q[j].sof !== (j % 256 == 0) || q[j].last !== (j % 256 == 255) || q[j].cyc != q[0].cyc + j) begin
        errors++;
        $display("FAIL b2b_sample %0d got r=%0d i=%0d cyc=%0d want r=%0d i=%0d cyc=%0d",
                 j, q[j].r, q[j].i, q[j].cyc, exp_r(2 + j / 256, j % 256), exp_i(2 + j / 256, j % 256), q[0].cyc + j);
      end
    end
    checks++; if (overflow !== 1'b0 || misalign !== 1'b0) begin errors++; $display("FAIL b2b_flags got %b%b want 00", overflow, misalign); end
  endtask

  task automatic test_stall;
    q.delete();
    fork
      begin
        drive_frame(10, 256, 1'b0);
        drive_frame(11, 256, 1'b0);
      end
      begin
        bit          stalled = 1'b0;
        logic [34:0] held = '0;
        for (int c = 0; c < 3000 && q.size() < 512; c++) begin
          @(negedge clk);
          if (stalled) begin
            checks++;
            if ({bus.out_valid, bus.out_sof, bus.out_last, bus.data_out_r, bus.data_out_i} !== held) begin
              errors++; $display("FAIL stall_hold cycle %0d got %h want %h", cyc,
                                 {bus.out_valid, bus.out_sof, bus.out_last, bus.data_out_r, bus.data_out_i}, held);
            end
          end
          stalled = bus.out_valid && !bus.out_ready;
          held    = {bus.out_valid, bus.out_sof, bus.out_last, bus.data_out_r, bus.data_out_i};
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join
    repeat (20) @(posedge clk); #1;
    checks++; if (q.size() != 512) begin errors++; $display("FAIL stall_count got %0d want 512", q.size()); end
    for (int j = 0; j < q.size() && j < 512; j++) begin
      checks++;
      if (q[j].r !== exp_r(10 + j / 256, j % 256) || q[j].i !== exp_i(10 + j / 256, j % 256) ||
          q[j].sof !== (j % 256 == 0) || q[j].last !== (j % 256 == 255)) begin
        errors++;
        $display("FAIL stall_sample %0d got r=%0d i=%0d want r=%0d i=%0d",
                 j, q[j].r, q[j].i, exp_r(10 + j / 256, j % 256), exp_i(10 + j / 256, j % 256));
      end
    end
  endtask

  task automatic test_overflow;
    q.delete();
    bus.out_ready = 1'b0;
    drive_frame(20, 256, 1'b0);
    drive_frame(21, 256, 1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow); end
    drive_frame(22, 256, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.data_out_r !== 16'(256 * 20)) begin
      errors++; $display("FAIL ovf_hold got v=%b r=%0d want v=1 r=%0d", bus.out_valid, bus.data_out_r, 256 * 20);
    end
    bus.out_ready = 1'b1;
    wait_outputs(512, 1000);
    repeat (300) @(posedge clk); #1;
    checks++; if (q.size() != 512) begin errors++; $display("FAIL ovf_count got %0d want 512", q.size()); end
    for (int j = 0; j < q.size() && j < 512; j++) begin
      checks++;
      if (q[j].r !== exp_r(20 + j / 256, j % 256) || q[j].i !== exp_i(20 + j / 256, j % 256) ||
          q[j].sof !== (j % 256 == 0) || q[j].last !== (j % 256 == 255)) begin
        errors++;
        $display("FAIL ovf_sample %0d got r=%0d i=%0d want r=%0d i=%0d",
                 j, q[j].r, q[j].i, exp_r(20 + j / 256, j % 256), exp_i(20 + j / 256, j % 256));
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
  endtask

  task automatic test_misalign;
    q.delete();
    bus.out_ready = 1'b1;
    drive_frame(30, 100, 1'b0);
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_early got %b want 0", misalign); end
    drive_frame(31, 256, 1'b0);
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_set got %b want 1", misalign); end
    wait_outputs(256, 600);
    repeat (20) @(posedge clk); #1;
    checks++; if (q.size() != 256) begin errors++; $display("FAIL mis_count got %0d want 256", q.size()); end
    for (int j = 0; j < q.size() && j < 256; j++) begin
      checks++;
      if (q[j].r !== exp_r(31, j) || q[j].i !== exp_i(31, j) || q[j].sof !== (j == 0) || q[j].last !== (j == 255)) begin
        errors++;
        $display("FAIL mis_sample %0d got r=%0d i=%0d want r=%0d i=%0d", j, q[j].r, q[j].i, exp_r(31, j), exp_i(31, j));
      end
    end
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_clear got %b want 0", misalign); end
    // Clear asserted in the same cycle as a fresh misaligned in_sof.
    q.delete();
    drive_frame(32, 50, 1'b0);
    drive_frame(33, 256, 1'b1);
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_set_wins got %b want 1", misalign); end
    wait_outputs(256, 600);
    repeat (20) @(posedge clk); #1;
    checks++;
    if (q.size() != 256 || q[0].r !== exp_r(33, 0) || q[255].r !== exp_r(33, 255)) begin
      errors++; $display("FAIL mis2_frame got count=%0d want 256 of frame 33", q.size());
    end
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  task automatic test_reset_mid;
    q.delete();
    bus.out_ready = 1'b1;
    drive_frame(6, 256, 1'b0);
    drive_frame(7, 60, 1'b0);
    drive_frame(7, 10, 1'b0);
    checks++; if (bus.out_valid !== 1'b1 || misalign !== 1'b1) begin errors++; $display("FAIL pre_reset got v=%b mis=%b want 1 1", bus.out_valid, misalign); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_sof !== 1'b0 || bus.out_last !== 1'b0) begin errors++; $display("FAIL async_reset_ctrl got v=%b sof=%b last=%b want 000", bus.out_valid, bus.out_sof, bus.out_last); end
    checks++; if (bus.data_out_r !== 16'sd0 || bus.data_out_i !== 16'sd0) begin errors++; $display("FAIL async_reset_data got %0d/%0d want 0/0", bus.data_out_r, bus.data_out_i); end
    checks++; if (misalign !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL async_reset_flags got %b%b want 00", misalign, overflow); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
    repeat (3) @(posedge clk); #1;
    drive_frame(8, 256, 1'b0);
    wait_outputs(256, 600);
    repeat (20) @(posedge clk); #1;
    checks++; if (q.size() != 256) begin errors++; $display("FAIL post_reset_count got %0d want 256", q.size()); end
    for (int j = 0; j < q.size() && j < 256; j++) begin
      checks++;
      if (q[j].r !== exp_r(8, j) || q[j].i !== exp_i(8, j) || q[j].sof !== (j == 0) || q[j].last !== (j == 255)) begin
        errors++;
        $display("FAIL post_reset_sample %0d got r=%0d i=%0d want r=%0d i=%0d", j, q[j].r, q[j].i, exp_r(8, j), exp_i(8, j));
      end
    end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL post_reset_mis got %b want 0", misalign); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_misalign();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
